// File: rtl/hd_err_inject_ctrl_pkg.sv
// Shared types, constants and helpers for the Hamming
// error-injection controller.
package hd_inject_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'd0,
    MODE_FIXED  = 2'd1,
    MODE_SWEEP  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int b = 0; b < 32; b++) c = c + 6'(v[b]);
    return c;
  endfunction

endpackage

// File: rtl/hd_err_inject_ctrl_if.sv
// Codeword stream in and corrupted stream out, valid/ready on
// both sides; slave is the injector, master the environment.
interface hd_err_inject_ctrl_if #(
  parameter int N = 7
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [N-1:0] out_mask;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/hd_err_inject_ctrl_lfsr.sv
// 32-bit right-shifting Galois LFSR, one step per enable.
// Seed must be nonzero or the register locks up.
module hd_lfsr32
  import hd_inject_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] state
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (en) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 32'h0);
    end
  end
endmodule

// File: rtl/hd_err_inject_ctrl.sv
// Sequenced error injector between Hamming encoder and decoder:
// flips 0-3 bits per codeword and tracks burst statistics.
module hd_err_inject_ctrl
  import hd_inject_pkg::*;
#(
  parameter int          K         = 4,
  parameter int          M         = 3,
  parameter logic [31:0] LFSR_SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cfg_mode,
  input  logic [1:0]  cfg_num_errs,
  input  logic [4:0]  cfg_pos0,
  input  logic [4:0]  cfg_pos1,
  input  logic [4:0]  cfg_pos2,
  input  logic [15:0] cfg_burst_len,
  input  logic        start,
  input  logic        stop,
  hd_err_inject_ctrl_if.slave io,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_cnt,
  output logic [17:0] flips_cnt
);
  localparam int N = K + M;
  localparam logic [4:0]  NM1 = 5'(N - 1);
  localparam logic [4:0]  NM2 = 5'(N - 2);
  localparam logic [12:0] NW  = 13'(N);

  state_e       state_q, state_d;
  mode_e        mode_q;
  logic [1:0]   ne_q;
  logic [4:0]   pos0_q, pos1_q, pos2_q;
  logic [15:0]  burst_q, acc_q;
  logic         stop_pend_q;
  logic [4:0]   si_q, sj_q, si_d, sj_d, sk;
  logic [31:0]  lfsr;
  logic         lfsr_unused;
  logic         start_go, closed, accept;
  logic         out_hs, last_hs;
  logic         em1, em2, em3;
  logic [4:0]   rp0, rp1, rp2;
  logic [N-1:0] mask_rnd, mask_fix, mask_swp, mask;
  logic         ov_q;
  logic [N-1:0] od_q, om_q;
  logic [18:0]  fsum;

  function automatic logic [N-1:0] onehot(input logic [4:0] p);
    logic [31:0] t;
    t = 32'd1 << p;
    return ({27'd0, p} < 32'(N)) ? t[N-1:0] : '0;
  endfunction

  hd_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept && mode_q == MODE_RANDOM),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[31:24];

  assign start_go = (state_q == ST_IDLE) && start;
  assign out_hs   = ov_q && io.out_ready;
  assign last_hs  = out_hs && (burst_q != 16'd0) &&
                    ({1'b0, words_cnt} + 17'd1 == {1'b0, burst_q});
  // Intake shuts after the last burst slot or once stop is pending.
  assign closed   = stop_pend_q ||
                    ((burst_q != 16'd0) && (acc_q == burst_q));
  assign io.in_ready = busy && !closed && !stop &&
                       (!ov_q || io.out_ready);
  assign accept   = io.in_valid && io.in_ready;

  assign io.out_valid = ov_q;
  assign io.out_data  = od_q;
  assign io.out_mask  = om_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_hs || (out_hs && stop_pend_q) ||
            (stop && (!ov_q || io.out_ready)))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_RANDOM;
      ne_q        <= '0;
      pos0_q      <= '0;
      pos1_q      <= '0;
      pos2_q      <= '0;
      burst_q     <= '0;
      acc_q       <= '0;
      stop_pend_q <= 1'b0;
    end else if (start_go) begin
      unique case (cfg_mode)
        2'd0:    mode_q <= MODE_RANDOM;
        2'd2:    mode_q <= MODE_SWEEP;
        default: mode_q <= MODE_FIXED;
      endcase
      ne_q        <= cfg_num_errs;
      pos0_q      <= cfg_pos0;
      pos1_q      <= cfg_pos1;
      pos2_q      <= cfg_pos2;
      burst_q     <= cfg_burst_len;
      acc_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      if (accept) acc_q <= acc_q + 16'd1;
      if (busy && stop && ov_q && !io.out_ready)
        stop_pend_q <= 1'b1;
    end
  end

  assign em1 = ne_q != 2'd0;
  assign em2 = ne_q[1];
  assign em3 = ne_q == 2'd3;

  assign rp0 = 5'(({5'd0, lfsr[7:0]}   * NW) >> 8);
  assign rp1 = 5'(({5'd0, lfsr[15:8]}  * NW) >> 8);
  assign rp2 = 5'(({5'd0, lfsr[23:16]} * NW) >> 8);
  assign sk  = (sj_q == NM1) ? 5'd0 : sj_q + 5'd1;

  always_comb begin
    mask_rnd = (em1 ? onehot(rp0) : '0) ^
               (em2 ? onehot(rp1) : '0) ^
               (em3 ? onehot(rp2) : '0);
    mask_fix = (em1 ? onehot(pos0_q) : '0) ^
               (em2 ? onehot(pos1_q) : '0) ^
               (em3 ? onehot(pos2_q) : '0);
    mask_swp = (em1 ? onehot(si_q) : '0) |
               (em2 ? onehot(sj_q) : '0) |
               ((em3 && sk != si_q) ? onehot(sk) : '0);
    unique case (mode_q)
      MODE_RANDOM: mask = mask_rnd;
      MODE_SWEEP:  mask = mask_swp;
      default:     mask = mask_fix;
    endcase
  end

  // Pairs advance lexicographically over i<j, wrapping to (0,1).
  always_comb begin
    si_d = si_q;
    sj_d = sj_q;
    unique case (ne_q)
      2'd1: si_d = (si_q == NM1) ? 5'd0 : si_q + 5'd1;
      2'd2, 2'd3: begin
        if (sj_q != NM1) begin
          sj_d = sj_q + 5'd1;
        end else if (si_q == NM2) begin
          si_d = 5'd0;
          sj_d = 5'd1;
        end else begin
          si_d = si_q + 5'd1;
          sj_d = si_q + 5'd2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      si_q <= 5'd0;
      sj_q <= 5'd1;
    end else if (start_go) begin
      si_q <= 5'd0;
      sj_q <= 5'd1;
    end else if (accept && mode_q == MODE_SWEEP) begin
      si_q <= si_d;
      sj_q <= sj_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      od_q <= '0;
      om_q <= '0;
    end else if (accept) begin
      ov_q <= 1'b1;
      od_q <= io.in_data ^ mask;
      om_q <= mask;
    end else if (out_hs) begin
      ov_q <= 1'b0;
    end
  end

  assign fsum = {1'b0, flips_cnt} + 19'(popcount(32'(om_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_cnt <= '0;
      flips_cnt <= '0;
    end else if (start_go) begin
      words_cnt <= '0;
      flips_cnt <= '0;
    end else if (out_hs) begin
      if (words_cnt != 16'hFFFF) words_cnt <= words_cnt + 16'd1;
      flips_cnt <= fsum[18] ? 18'h3FFFF : fsum[17:0];
    end
  end
endmodule

// File: doc/hd_err_inject_ctrl.md
Name: hd_err_inject_ctrl

Overview:
- Synthesizable, sequenced error-injection controller for the Hamming test path: encoder -> hd_err_inject_ctrl -> decoder.
- Accepts codewords on a valid/ready stream and flips 0-3 bits per word: random, fixed-position, or exhaustive sweep.
- Emits the corrupted word plus its error mask. Runs bursts of a programmed length and keeps word/flip statistics for the scoreboard.

Parameters:
- K, 4, data bits per codeword
- M, 3, parity bits per codeword; N = K+M, N <= 32
- LFSR_SEED, 32'h1, reset value of random LFSR (must be nonzero)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_mode  in  2  0=random, 1=fixed, 2=sweep, 3=reserved (behaves as 1)
- cfg_num_errs  in  2  errors per word, 0-3
- cfg_pos0 / cfg_pos1 / cfg_pos2  in  5 each  fixed-mode flip positions
- cfg_burst_len  in  16  words per burst; 0 = unbounded
- start  in  1  pulse; latches cfg_*, clears counters, enters RUN
- stop  in  1  pulse; ends burst
- in_valid  in  1  codeword valid
- in_ready  out  1  controller can accept
- in_data  in  N  clean codeword
- out_valid  out  1  corrupted word valid
- out_ready  in  1  downstream accepts
- out_data  out  N  corrupted codeword
- out_mask  out  N  bits flipped (out_data ^ in_data)
- busy  out  1  state == RUN
- done  out  1  one-cycle pulse on RUN->DONE
- words_cnt  out  16  words emitted this burst
- flips_cnt  out  18  sum of popcount(out_mask) this burst

Behaviour:
- Reset: state IDLE; out_valid=0; out_data=0; out_mask=0; done=0; words_cnt=0; flips_cnt=0; LFSR=LFSR_SEED; sweep indices i=0, j=1.
- FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when the output handshake completes with words_cnt+1 == burst_len (burst_len != 0), or on stop.
  - DONE -> IDLE after 1 cycle, with done=1 for that cycle.
  - start in RUN/DONE is ignored.
- cfg_* is sampled only on start and held in shadow registers for the burst.
- Handshake:
  - in_ready = busy && (!out_valid || out_ready).
  - Input is accepted when in_valid && in_ready, giving 1-cycle latency to out_valid.
  - out_data/out_mask are held stable while out_valid && !out_ready.
- Accepting a word in the last burst slot closes intake: no further words are accepted after burst_len acceptances.
- stop with a word held in the output register: the word still drains, and DONE is entered after it completes.
- Mask generation by mode (only the first cfg_num_errs positions are used; num_errs=0 gives mask=0 in all modes):
  - Random: 32-bit Galois LFSR, taps 32'h80200003, advances one step per accepted word.
    - Position p_j = (lfsr[8j+7:8j] * N) >> 8 for j=0..2.
    - mask = XOR of the one-hot p_j, so duplicate positions cancel (channel model semantics).
  - Fixed: mask = XOR of onehot(cfg_pos_j). Positions >= N contribute nothing.
  - Sweep, num_errs=1: mask = onehot(i); i increments per word and wraps N-1 -> 0.
  - Sweep, num_errs=2: mask = onehot(i)|onehot(j) over pairs i<j in lexicographic order. After (N-2,N-1) it wraps to (0,1).
  - Sweep, num_errs=3: mask = onehot(i)|onehot(j)|onehot(j+1 mod N), with j+1 skipped if it equals i.
  - Sweep indices reset to (0,1) on start.
- Counters:
  - words_cnt increments on output handshake, saturating at 16'hFFFF.
  - flips_cnt adds popcount(out_mask) on output handshake, saturating.
  - Both are cleared on start and held in IDLE/DONE.
- Simultaneous start and stop in IDLE: start wins. In RUN, stop wins.
- Async reset mid-burst: all state returns to reset values immediately, and the in-flight word is dropped.

Decomposition:
- Package hd_inject_pkg holds:
  - mode enum (MODE_RANDOM, MODE_FIXED, MODE_SWEEP)
  - FSM state enum
  - LFSR tap constant 32'h80200003
  - popcount function
- One sub-module, hd_lfsr32: enable, seed parameter, 32-bit state output.
- The mask/sweep logic and the FSM stay in the top module.

Test Plan:
- K=4, M=3, mode=1, num_errs=1, pos0=2, burst=3, in_data=7'h55 x3 -> three outputs 7'h51, mask 7'h04; words_cnt=3, flips_cnt=3, done pulses once; a fourth in_valid sees in_ready=0.
- Mode=2, num_errs=1, burst=8, in_data=0 -> masks 01,02,04,08,10,20,40,01 (wrap); flips_cnt=8.
- Mode=2, num_errs=2, burst=22 -> 21 distinct pairs (0,1)..(5,6), then (0,1); every mask has popcount 2.
- Mode=1, num_errs=2, pos0=pos1=3 -> mask=0, out_data==in_data, flips_cnt unchanged.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_mask stable and in_ready=0; on release, one handshake and the next word is accepted the same cycle.
- Mode=0, seed=1, burst=0 (unbounded), 1000 words then stop -> popcount(mask) in {1,3} for num_errs=3, all positions < 7, matches reference LFSR model; rst_n low mid-stream -> out_valid=0 and counters=0 within the same cycle.
